// File: rtl/qspi_fill_arbiter.sv
// rtl/qspi_fill_arbiter.sv - round-robin arbiter sharing one QSPI line reader between two fill requesters
// Same-line ties merge into one read; a watchdog turns a missing fr_done into an all-zero err completion.
module qspi_fill_arbiter #(
  parameter int LINE_SIZE = 128,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [23:0]          addr0,
  input  logic [23:0]          addr1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 err,
  output logic [LINE_SIZE-1:0] line,
  output logic                 busy,
  output logic [1:0]           owner,
  output logic                 fr_rd,
  output logic [23:0]          fr_addr,
  input  logic                 fr_done,
  input  logic [LINE_SIZE-1:0] fr_line
);

  localparam int          OFS        = $clog2(LINE_SIZE / 8);
  localparam logic [23:0] ALIGN_MASK = ~((24'd1 << OFS) - 24'd1);
  localparam logic [15:0] TO16       = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic [1:0]            owner_q, owner_d;
  logic [23:0]           fr_addr_q, fr_addr_d;
  logic [LINE_SIZE-1:0]  line_q, line_d;
  logic                  errf_q, errf_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           cnt_inc;
  logic                  win1;
  logic                  same_line;

  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign same_line = (addr0 & ALIGN_MASK) == (addr1 & ALIGN_MASK);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 2'b00;
      fr_addr_q <= 24'd0;
      line_q    <= '0;
      errf_q    <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      fr_addr_q <= fr_addr_d;
      line_q    <= line_d;
      errf_q    <= errf_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    fr_addr_d = fr_addr_q;
    line_d    = line_q;
    errf_d    = errf_q;
    cnt_d     = cnt_q;
    win1      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester granted last yields.
          win1      = req1 && (!req0 || !last_q);
          owner_d   = win1 ? 2'b10 : 2'b01;
          if (req0 && req1 && same_line) owner_d = 2'b11;
          fr_addr_d = (win1 ? addr1 : addr0) & ALIGN_MASK;
          last_d    = win1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 16'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (fr_done) begin
          line_d  = fr_line;
          state_d = ACK;
        end else if (cnt_inc >= TO16) begin
          line_d  = '0;
          errf_d  = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ACK: begin
        errf_d  = 1'b0;
        owner_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fr_rd   = (state_q == ISSUE);
  assign busy    = (state_q != IDLE);
  assign ack0    = (state_q == ACK) && owner_q[0];
  assign ack1    = (state_q == ACK) && owner_q[1];
  assign err     = (state_q == ACK) && errf_q;
  assign owner   = owner_q;
  assign fr_addr = fr_addr_q;
  assign line    = line_q;

endmodule

// File: tb/tb_qspi_fill_arbiter.sv
// tb/tb_qspi_fill_arbiter.sv - directed and randomized bench for qspi_fill_arbiter
// dut_a uses the default watchdog, dut_b a short one; both share all inputs.
module tb_qspi_fill_arbiter;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic         HRESETn, req0, req1, fr_done;
  logic [23:0]  addr0, addr1;
  logic [127:0] fr_line;

  logic         a_ack0, a_ack1, a_err, a_busy, a_fr_rd;
  logic [127:0] a_line;
  logic [1:0]   a_owner;
  logic [23:0]  a_fr_addr;
  logic         b_ack0, b_ack1, b_err, b_busy, b_fr_rd;
  logic [127:0] b_line;
  logic [1:0]   b_owner;
  logic [23:0]  b_fr_addr;

  qspi_fill_arbiter #(.LINE_SIZE(128), .TIMEOUT(1023)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .ack0(a_ack0), .ack1(a_ack1), .err(a_err), .line(a_line), .busy(a_busy), .owner(a_owner),
    .fr_rd(a_fr_rd), .fr_addr(a_fr_addr), .fr_done(fr_done), .fr_line(fr_line));

  qspi_fill_arbiter #(.LINE_SIZE(128), .TIMEOUT(15)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .ack0(b_ack0), .ack1(b_ack1), .err(b_err), .line(b_line), .busy(b_busy), .owner(b_owner),
    .fr_rd(b_fr_rd), .fr_addr(b_fr_addr), .fr_done(fr_done), .fr_line(fr_line));

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  bit m_last;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
    if (a_fr_rd) rd_cnt++;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    req0 = 1'b0; req1 = 1'b0; fr_done = 1'b0; fr_line = '0;
    addr0 = 24'd0; addr1 = 24'd0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    m_last = 1'b1;
  endtask

  // Reference arbitration: sole requester wins, a tie goes to the one not granted last.
  task automatic arb(input bit r0, input bit r1, input logic [23:0] a0, input logic [23:0] a1,
                     input bit last, output bit win, output logic [1:0] own, output logic [23:0] fa);
    win = (r0 && r1) ? !last : r1;
    own = win ? 2'b10 : 2'b01;
    if (r0 && r1 && (a0 >> 4) == (a1 >> 4)) own = 2'b11;
    fa = win ? {a1[23:4], 4'h0} : {a0[23:4], 4'h0};
  endtask

  task automatic wait_rd(output int n);
    n = 0;
    while (!a_fr_rd && n < 20) begin
      step();
      n++;
    end
    chk("fr_rd_seen", 128'(a_fr_rd), 128'(1));
  endtask

  // Called in the fr_rd cycle: returns done lat cycles later and checks the ack cycle.
  task automatic finish(input int lat, input logic [127:0] d, input logic [1:0] own, input bit with_b);
    bit early = 1'b0;
    int r0c = rd_cnt;
    for (int i = 0; i < lat; i++) begin
      step();
      if (a_ack0 || a_ack1 || a_err) early = 1'b1;
    end
    chk("ack_early", 128'(early), 128'(0));
    chk("rd_during_wait", 128'(rd_cnt - r0c), 128'(0));
    fr_done = 1'b1;
    fr_line = d;
    step();
    fr_done = 1'b0;
    chk("ack0", 128'(a_ack0), 128'(own[0]));
    chk("ack1", 128'(a_ack1), 128'(own[1]));
    chk("err", 128'(a_err), 128'(0));
    chk("line", a_line, d);
    if (with_b) begin
      chk("b_ack0", 128'(b_ack0), 128'(own[0]));
      chk("b_err", 128'(b_err), 128'(0));
      chk("b_line", b_line, d);
    end
    if (own[0]) req0 = 1'b0;
    if (own[1]) req1 = 1'b0;
    step();
    chk("idle_busy", 128'(a_busy), 128'(0));
    chk("idle_owner", 128'(a_owner), 128'(0));
  endtask

  task automatic read(input int lat, input logic [127:0] d, input logic [1:0] own,
                      input logic [23:0] fa, input bit with_b, output int n);
    wait_rd(n);
    chk("fr_addr", 128'(a_fr_addr), 128'(fa));
    chk("owner", 128'(a_owner), 128'(own));
    chk("busy", 128'(a_busy), 128'(1));
    finish(lat, d, own, with_b);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  int n, r, k;
  bit win;
  logic [1:0] own;
  logic [23:0] fa;
  logic [127:0] d;

  initial begin
    do_reset();
    chk("rst_fr_rd", 128'(a_fr_rd), 128'(0));
    chk("rst_fr_addr", 128'(a_fr_addr), 128'(0));
    chk("rst_ack", 128'({a_ack0, a_ack1}), 128'(0));
    chk("rst_err", 128'(a_err), 128'(0));
    chk("rst_line", a_line, 128'(0));
    chk("rst_busy", 128'(a_busy), 128'(0));
    chk("rst_owner", 128'(a_owner), 128'(0));

    // Single request, reader latency 40
    req0 = 1'b1; addr0 = 24'h012345;
    r = rd_cnt;
    read(40, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 2'b01, 24'h012340, 1'b0, n);
    chk("single_one_rd", 128'(rd_cnt - r), 128'(1));

    // Tie after reset, then tie after a solo req0 grant
    do_reset();
    req0 = 1'b1; addr0 = 24'h000100; req1 = 1'b1; addr1 = 24'h000200;
    read(7, 128'h11, 2'b01, 24'h000100, 1'b0, n);
    read(5, 128'h22, 2'b10, 24'h000200, 1'b0, n);
    chk("tie_rd_ack_plus2", 128'(n), 128'(1));
    req0 = 1'b1; addr0 = 24'h000400;
    read(3, 128'h33, 2'b01, 24'h000400, 1'b0, n);
    req0 = 1'b1; addr0 = 24'h000500; req1 = 1'b1; addr1 = 24'h000600;
    read(4, 128'h44, 2'b10, 24'h000600, 1'b0, n);
    read(4, 128'h55, 2'b01, 24'h000500, 1'b0, n);

    // Merge of same-line requests
    req0 = 1'b1; addr0 = 24'h0ABC04; req1 = 1'b1; addr1 = 24'h0ABC0C;
    r = rd_cnt;
    read(9, 128'h66, 2'b11, 24'h0ABC00, 1'b0, n);
    repeat (3) step();
    chk("merge_one_rd", 128'(rd_cnt - r), 128'(1));

    // Late arrival while req0 is in WAIT
    req0 = 1'b1; addr0 = 24'h001230;
    wait_rd(n);
    chk("late_fr_addr", 128'(a_fr_addr), 128'(24'h001230));
    repeat (5) step();
    req1 = 1'b1; addr1 = 24'h004560;
    finish(12, 128'h77, 2'b01, 1'b0);
    read(6, 128'h88, 2'b10, 24'h004560, 1'b0, n);
    chk("late_rd_ack_plus2", 128'(n), 128'(1));

    // Reset during WAIT with a stale fr_done around release
    req0 = 1'b1; addr0 = 24'h0FFFF8;
    wait_rd(n);
    repeat (4) step();
    @(posedge HCLK);
    #3 HRESETn = 1'b0; fr_done = 1'b1; fr_line = '1;
    #1;
    chk("arst_busy", 128'(a_busy), 128'(0));
    chk("arst_fr_rd", 128'(a_fr_rd), 128'(0));
    chk("arst_fr_addr", 128'(a_fr_addr), 128'(0));
    chk("arst_owner", 128'(a_owner), 128'(0));
    chk("arst_ack_err", 128'({a_ack0, a_ack1, a_err}), 128'(0));
    chk("arst_line", a_line, 128'(0));
    @(posedge HCLK);
    #4 HRESETn = 1'b1;
    step();
    fr_done = 1'b0;
    chk("rerun_fr_rd", 128'(a_fr_rd), 128'(1));
    chk("rerun_fr_addr", 128'(a_fr_addr), 128'(24'h0FFFF0));
    chk("stale_done_line", a_line, 128'(0));
    finish(3, 128'h99, 2'b01, 1'b0);

    // Watchdog on dut_b (TIMEOUT=15)
    do_reset();
    req0 = 1'b1; addr0 = 24'h222222;
    read(5, 128'hA5A5, 2'b01, 24'h222220, 1'b1, n);
    req0 = 1'b1; addr0 = 24'h333330;
    wait_rd(n);
    chk("b_fr_rd", 128'(b_fr_rd), 128'(1));
    k = 0;
    do begin
      step();
      k++;
    end while (!b_ack0 && k < 40);
    chk("to_latency", 128'(k), 128'(16));
    chk("to_err", 128'(b_err), 128'(1));
    chk("to_line", b_line, 128'(0));
    chk("to_ack1", 128'(b_ack1), 128'(0));
    chk("to_a_waiting", 128'(a_ack0), 128'(0));
    req0 = 1'b0;
    step();
    chk("to_err_pulse", 128'(b_err), 128'(0));
    fr_done = 1'b1; fr_line = 128'hBAD;
    step();
    fr_done = 1'b0;
    chk("a_late_ack", 128'(a_ack0), 128'(1));
    chk("b_idle_done_ignored", b_line, 128'(0));
    step();
    req0 = 1'b1; addr0 = 24'h444440;
    read(4, 128'h5A5A, 2'b01, 24'h444440, 1'b1, n);

    // Randomized traffic against the reference arbitration
    do_reset();
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(1, 3);
      addr0 = 24'($urandom);
      addr1 = ($urandom_range(0, 2) == 0) ? (addr0 ^ 24'($urandom_range(0, 15))) : 24'($urandom);
      req0 = r[0];
      req1 = r[1];
      while (req0 || req1) begin
        arb(req0, req1, addr0, addr1, m_last, win, own, fa);
        m_last = win;
        d = {$urandom, $urandom, $urandom, $urandom};
        read($urandom_range(1, 25), d, own, fa, 1'b0, n);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
